// File: rtl/instr_pkg.sv
// Shared constants for the instruction encoder: opcodes, field positions and FSM states.
package instr_pkg;
  localparam logic [3:0] OP_SRC_REG = 4'b0010;
  localparam logic [3:0] OP_BRANCH  = 4'b0011;

  // Field positions in the default 32-bit word.
  localparam int OPCODE_LSB = 28;
  localparam int CC_LSB     = 24;
  localparam int SRC_LSB    = 12;
  localparam int DEST_LSB   = 0;

  // Word bits 27 and 26 expressed as indices into the 4-bit cc field.
  localparam int CC_FORCE_IDX = 27 - CC_LSB;
  localparam int CC_DROP_IDX  = 26 - CC_LSB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/instruction_encoder_if.sv
// Field-input and instruction-memory write handshakes of the encoder.
interface instruction_encoder_if #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_opcode;
  logic [3:0]               in_cc;
  logic [ADDRESS_WIDTH-1:0] in_src;
  logic [ADDRESS_WIDTH-1:0] in_dest;
  logic                     mem_we;
  logic                     mem_ready;
  logic [ADDRESS_WIDTH-1:0] mem_adrs;
  logic [DATA_WIDTH-1:0]    mem_wdata;

  modport master (
    output in_valid, in_opcode, in_cc, in_src, in_dest, mem_ready,
    input  in_ready, mem_we, mem_adrs, mem_wdata
  );

  modport slave (
    input  in_valid, in_opcode, in_cc, in_src, in_dest, mem_ready,
    output in_ready, mem_we, mem_adrs, mem_wdata
  );
endinterface

// File: rtl/encoder_fifo.sv
// Encoded-word FIFO; a push while full is accepted when a pop frees the slot in the same cycle.
module encoder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]                 wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end
endmodule

// File: rtl/instruction_encoder.sv
// Packs instruction fields into words and streams them to instruction memory.
// Optional field checking is enabled with the ENCODER_CHECK_EN macro.
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_adrs,
  input  logic [ADDRESS_WIDTH-1:0] count,
  instruction_encoder_if.slave     bus,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               err_count
);
  localparam int AW = ADDRESS_WIDTH;

  state_t          state, state_d;
  logic [AW-1:0]   cnt_q, accepted, retired, adrs_q;
  logic [3:0]      cc_eff;
  logic            drop, accept, push, pop, start_load;
  logic            full, empty;
  logic [DATA_WIDTH-1:0] word, head;

  always_comb begin
    cc_eff = bus.in_cc;
    drop   = 1'b0;
`ifdef ENCODER_CHECK_EN
    if (bus.in_opcode == OP_SRC_REG) cc_eff[CC_FORCE_IDX] = 1'b1;
    if (bus.in_opcode == OP_BRANCH && bus.in_cc[CC_DROP_IDX]) drop = 1'b1;
`endif
  end

  assign word       = DATA_WIDTH'({bus.in_opcode, cc_eff, bus.in_src, bus.in_dest});
  assign start_load = (state == ST_IDLE) && start;
  assign bus.in_ready = (state == ST_LOAD) && !full && (accepted < cnt_q);
  assign accept     = bus.in_valid && bus.in_ready;
  assign push       = accept && !drop;
  assign pop        = bus.mem_we && bus.mem_ready;

  encoder_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (word),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.mem_we    = !empty;
  assign bus.mem_wdata = empty ? '0 : head;
  assign bus.mem_adrs  = adrs_q;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (start) state_d = (count == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: if (retired == cnt_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop and a drop can land in the same cycle, so retired may advance by two.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      accepted <= '0;
      retired  <= '0;
      adrs_q   <= '0;
    end else if (start_load) begin
      cnt_q    <= count;
      accepted <= '0;
      retired  <= '0;
      adrs_q   <= base_adrs;
    end else begin
      if (accept) accepted <= accepted + AW'(1);
      retired <= retired + AW'(pop) + AW'(accept && drop);
      if (pop) adrs_q <= adrs_q + AW'(1);
    end
  end

`ifdef ENCODER_CHECK_EN
  logic [7:0] err_q;
  always_ff @(posedge clk) begin
    if (reset)                                    err_q <= 8'h00;
    else if (accept && drop && err_q != 8'hFF)    err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif
endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-002 Parameter ADDRESS_WIDTH, default 12, SHALL set the width of the memory address and the operand fields.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the encoded-word buffer depth (power of 2).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
REQ-007 base_adrs  in  ADDRESS_WIDTH  first instruction-memory address, captured on start.
REQ-008 count  in  ADDRESS_WIDTH  number of instructions in the load, captured on start.
REQ-009 in_valid / in_ready  in / out  1 / 1  field-input handshake.
REQ-010 in_opcode, in_cc, in_src, in_dest  in  4, 4, ADDRESS_WIDTH, ADDRESS_WIDTH  instruction fields.
REQ-011 mem_we / mem_ready  out / in  1 / 1  instruction-memory write handshake.
REQ-012 mem_adrs, mem_wdata  out  ADDRESS_WIDTH, DATA_WIDTH  write address and data.
REQ-013 busy, done, err_count  out  1, 1, 8  status outputs.

Function
REQ-014 Encoding SHALL be word = {opcode, cc, src, dest}, occupying bits [31:28], [27:24], [23:12] and [11:0].
REQ-015 The FSM SHALL have states IDLE, LOAD and DONE; start moves IDLE to LOAD, capturing base_adrs and count.
REQ-016 start with count==0 SHALL go directly to DONE.
REQ-017 In LOAD, in_ready SHALL be 1 when the FIFO is not full and accepted < count; in_ready SHALL be 0 in every other state.
REQ-018 An accepted word SHALL be pushed to the FIFO in the same cycle and SHALL appear on mem_wdata no earlier than the following cycle.
REQ-019 mem_we SHALL equal FIFO not-empty; a pop SHALL occur when mem_we and mem_ready are both 1.
REQ-020 mem_adrs SHALL start at base_adrs, increment by 1 per pop, and wrap from 2^ADDRESS_WIDTH-1 to 0.
REQ-021 A push and a pop in the same cycle SHALL leave the occupancy unchanged, including when the FIFO is full.
REQ-022 retired SHALL increment on each pop or drop; retired==count SHALL move LOAD to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in LOAD and DONE.
REQ-025 start outside IDLE SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, flush the FIFO, and clear the counters.
REQ-027 Reset SHALL drive in_ready=0, mem_we=0, mem_adrs=0, mem_wdata=0, busy=0, done=0 and err_count=0.
REQ-028 Reset mid-LOAD SHALL discard every un-retired word with no further memory write.

Configuration
REQ-029 With ENCODER_CHECK_EN defined, opcode 4'b0010 SHALL have cc[27] forced to 1.
REQ-030 With ENCODER_CHECK_EN defined, opcode 4'b0011 with cc[26]=1 SHALL be dropped (counted as retired, never written) and SHALL increment err_count, which saturates at 255.
REQ-031 Without ENCODER_CHECK_EN, fields SHALL be encoded verbatim and err_count SHALL be tied to 0.

Structure
REQ-032 Package instr_pkg SHALL hold the opcode constants (OP_SRC_REG=4'b0010, OP_BRANCH=4'b0011), the field bit positions and the FSM state enum.
REQ-033 The FIFO SHALL be the sub-module encoder_fifo, with push/pop, full/empty and parameterised depth.

Verification
REQ-034 start, base 0x010, count 3, fields {1,0xC,0x005,0x007} with mem_ready=1 -> writes 0x1C005007 to 0x010, 0x011 and 0x012; done pulses once.
REQ-035 base 0xFFE, count 3 -> writes to 0xFFE, 0xFFF, then 0x000.
REQ-036 mem_ready=0 for 10 cycles, count 6 -> in_ready drops after 4 accepts; all 6 words written in order once mem_ready=1.
REQ-037 ENCODER_CHECK_EN set, {3,0x4,0,0x020} -> dropped, err_count=1; {2,0x0,1,2} -> word 0x28001002 written.
REQ-038 Reset asserted after 2 of 5 words -> next cycle mem_we=0 and busy=0; a subsequent start works normally.
REQ-039 count 0 -> done pulses within 2 cycles with no mem_we.
